// File: rtl/adc_frame_sequencer_if.sv
// Sample-in / framed-word-out stream bundle for adc_frame_sequencer.
// master = sequencer side, slave = ADC pipeline plus DDR3 write FIFO side.
interface adc_frame_sequencer_if #(
  parameter int NSAMP = 8,
  parameter int SW    = 13
);
  logic [NSAMP*SW-1:0]   in_dat;
  logic                  in_valid;
  logic                  in_ready;
  logic [NSAMP*16+3:0]   out_dat;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  in_dat, in_valid, out_ready,
    output in_ready, out_dat, out_valid
  );

  modport slave (
    output in_dat, in_valid, out_ready,
    input  in_ready, out_dat, out_valid
  );
endinterface

// File: rtl/adc_frame_sequencer.sv
// Frames a fill as header, per-waveform header + data bursts, then XOR checksum; 1-cycle beat-to-word
// latency through a single output register that stalls input on backpressure. Optional OVR_FLAG_EN.
module adc_frame_sequencer #(
  parameter int NSAMP    = 8,
  parameter int ADC_BITS = 12,
  parameter int SW       = ADC_BITS + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] fill_num,
  input  logic [1:0]  fill_type,
  input  logic        cbuf_mode,
  input  logic [11:0] channel_tag,
  input  logic [22:0] burst_start_adr,
  input  logic [13:0] num_bursts,
  input  logic [15:0] pre_trig,
  input  logic [22:0] num_waveforms,
  input  logic [3:0]  xadc_alarms,
  adc_frame_sequencer_if.master bus,
  output logic        busy,
  output logic        ovr_seen
);
  localparam int DW = NSAMP * 16;

  typedef enum logic [2:0] {IDLE, FILL_HDR, WF_HDR, DATA, CHKSUM} state_t;
  state_t state, state_nxt;

  logic [23:0] c_fill_num;
  logic [1:0]  c_fill_type;
  logic        c_cbuf_mode;
  logic [11:0] c_channel_tag;
  logic [22:0] c_adr;
  logic [13:0] c_num_bursts;
  logic [15:0] c_pre_trig;
  logic [22:0] c_num_wf;

  logic [22:0]   wf_idx, wf_adr, adr_step;
  logic [13:0]   beat_cnt;
  logic [DW-1:0] csum, fill_hdr, wf_hdr, data_word, pay_nxt;
  logic [3:0]    tag_nxt;
  logic [NSAMP-1:0] ovr_bits;
  logic load_ok, load, beat, wf_last, burst_last, start_acc, wf_ovr;

  assign start_acc   = (state == IDLE) && start && !busy;
  assign load_ok     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == DATA) && load_ok;
  assign wf_last     = (wf_idx + 23'd1) == c_num_wf;
  assign burst_last  = (beat_cnt + 14'd1) == c_num_bursts;
  assign adr_step    = (NSAMP == 16) ? {8'd0, c_num_bursts, 1'b0} : {9'd0, c_num_bursts};

  always_comb begin
    fill_hdr           = '0;
    fill_hdr[23:0]     = c_fill_num;
    fill_hdr[25:24]    = c_fill_type;
    fill_hdr[40:27]    = c_num_bursts;
    fill_hdr[52:41]    = c_pre_trig[11:0];
    fill_hdr[75:53]    = c_adr;
    fill_hdr[98:76]    = c_num_wf;
    fill_hdr[102:99]   = c_pre_trig[15:12];
    fill_hdr[103]      = c_cbuf_mode;
    fill_hdr[121:110]  = c_channel_tag;
    fill_hdr[127:126]  = 2'b01;

    wf_hdr             = '0;
    wf_hdr[13:0]       = c_num_bursts;
    wf_hdr[25:14]      = c_pre_trig[11:0];
    wf_hdr[51:26]      = {wf_adr, 3'b000};
    wf_hdr[74:52]      = wf_idx;
    wf_hdr[109:98]     = c_channel_tag;
    wf_hdr[113:110]    = xadc_alarms;
    wf_hdr[114]        = c_cbuf_mode;
    wf_hdr[115]        = wf_ovr;
    wf_hdr[127:126]    = 2'b01;

    // Drop the overrange LSB and sign-extend the ADC code to a 16-bit lane.
    data_word = '0;
    ovr_bits  = '0;
    for (int k = 0; k < NSAMP; k++) begin
      data_word[k*16 +: 16] = {{(16-ADC_BITS){bus.in_dat[k*SW+SW-1]}}, bus.in_dat[k*SW+1 +: ADC_BITS]};
      ovr_bits[k]           = bus.in_dat[k*SW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    beat      = 1'b0;
    tag_nxt   = 4'd0;
    pay_nxt   = '0;
    case (state)
      IDLE: if (start_acc) state_nxt = FILL_HDR;
      FILL_HDR: if (load_ok) begin
        load      = 1'b1;
        tag_nxt   = 4'd1;
        pay_nxt   = fill_hdr;
        state_nxt = (c_num_wf != 23'd0) ? WF_HDR : CHKSUM;
      end
      WF_HDR: if (load_ok) begin
        load    = 1'b1;
        tag_nxt = 4'd2;
        pay_nxt = wf_hdr;
        if (c_num_bursts != 14'd0) state_nxt = DATA;
        else                       state_nxt = wf_last ? CHKSUM : WF_HDR;
      end
      DATA: if (bus.in_valid && load_ok) begin
        load    = 1'b1;
        beat    = 1'b1;
        tag_nxt = 4'd3;
        pay_nxt = data_word;
        if (burst_last) state_nxt = wf_last ? CHKSUM : WF_HDR;
      end
      CHKSUM: if (load_ok) begin
        load      = 1'b1;
        tag_nxt   = 4'd4;
        pay_nxt   = csum;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_fill_num    <= '0;
      c_fill_type   <= '0;
      c_cbuf_mode   <= 1'b0;
      c_channel_tag <= '0;
      c_adr         <= '0;
      c_num_bursts  <= '0;
      c_pre_trig    <= '0;
      c_num_wf      <= '0;
      wf_idx        <= '0;
      wf_adr        <= '0;
      beat_cnt      <= '0;
      csum          <= '0;
      busy          <= 1'b0;
      bus.out_dat   <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (start_acc) begin
        c_fill_num    <= fill_num;
        c_fill_type   <= fill_type;
        c_cbuf_mode   <= cbuf_mode;
        c_channel_tag <= channel_tag;
        c_adr         <= burst_start_adr;
        c_num_bursts  <= num_bursts;
        c_pre_trig    <= pre_trig;
        c_num_wf      <= num_waveforms;
        wf_idx        <= '0;
        wf_adr        <= burst_start_adr;
        beat_cnt      <= '0;
        csum          <= '0;
        busy          <= 1'b1;
      end else if (bus.out_valid && bus.out_ready && bus.out_dat[DW+3:DW] == 4'd4) begin
        busy <= 1'b0;
      end

      if (load) begin
        bus.out_dat   <= {tag_nxt, pay_nxt};
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (load && state == FILL_HDR)                    csum <= pay_nxt;
      else if (load && (state == WF_HDR || state == DATA)) csum <= csum ^ pay_nxt;

      // Waveform index advances when its last word (header or final beat) is loaded.
      if (load && state == WF_HDR) begin
        wf_adr   <= wf_adr + adr_step;
        beat_cnt <= '0;
        if (c_num_bursts == 14'd0) wf_idx <= wf_idx + 23'd1;
      end
      if (beat) begin
        if (burst_last) begin
          beat_cnt <= '0;
          wf_idx   <= wf_idx + 23'd1;
        end else begin
          beat_cnt <= beat_cnt + 14'd1;
        end
      end
    end
  end

`ifdef OVR_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wf_ovr   <= 1'b0;
      ovr_seen <= 1'b0;
    end else if (start_acc) begin
      wf_ovr   <= 1'b0;
      ovr_seen <= 1'b0;
    end else begin
      if (load && state == WF_HDR) wf_ovr <= 1'b0;
      if (beat && |ovr_bits) begin
        wf_ovr   <= 1'b1;
        ovr_seen <= 1'b1;
      end
    end
  end
`else
  logic unused_ovr;
  assign unused_ovr = ^ovr_bits;
  assign wf_ovr     = 1'b0;
  assign ovr_seen   = 1'b0;
`endif
endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Randomised bench for adc_frame_sequencer: stream-level scoreboard plus literal spot checks.
module tb_adc_frame_sequencer;
  localparam int NSAMP = 8, ADC_BITS = 12, SW = ADC_BITS + 1, DW = NSAMP * 16;
  typedef logic [DW-1:0] pay_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [23:0] fill_num = '0;
  logic [1:0]  fill_type = '0;
  logic        cbuf_mode = 1'b0;
  logic [11:0] channel_tag = '0;
  logic [22:0] burst_start_adr = '0;
  logic [13:0] num_bursts = '0;
  logic [15:0] pre_trig = '0;
  logic [22:0] num_waveforms = '0;
  logic [3:0]  xadc_alarms = '0;
  logic busy, ovr_seen;

  adc_frame_sequencer_if #(.NSAMP(NSAMP), .SW(SW)) bus ();

  adc_frame_sequencer #(.NSAMP(NSAMP), .ADC_BITS(ADC_BITS), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .fill_num(fill_num), .fill_type(fill_type),
    .cbuf_mode(cbuf_mode), .channel_tag(channel_tag), .burst_start_adr(burst_start_adr),
    .num_bursts(num_bursts), .pre_trig(pre_trig), .num_waveforms(num_waveforms),
    .xadc_alarms(xadc_alarms), .bus(bus), .busy(busy), .ovr_seen(ovr_seen)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [3:0] exp_tag[$];
  pay_t       exp_pay[$];
  logic [NSAMP*SW-1:0] beat_q[$];
  logic [3:0] got_tag[$];
  pay_t       got_pay[$];
  bit csum_seen = 0, stalled = 0, force_lane0 = 0;
  bit m_wf_ovr = 0, m_fill_ovr = 0;
  pay_t m_csum, cp, accx;
  logic [3:0] ct;
  logic [NSAMP*SW-1:0] cb;
  logic [DW+3:0] stall_word;
  int rdy_mode = 0, rcnt = 0;
  logic [3:0] t1_tags [10] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};

  // Model view of the fill configuration captured at start.
  logic [23:0] m_fn;  logic [1:0] m_ft;  logic m_cb;  logic [11:0] m_tag;
  logic [22:0] m_adr; logic [13:0] m_nb; logic [15:0] m_pt; logic [22:0] m_nwf; logic [3:0] m_xa;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic pay_t data_of(input logic [NSAMP*SW-1:0] b);
    pay_t p = '0;
    for (int k = 0; k < NSAMP; k++) begin
      int v = int'(b[k*SW +: SW]) >> 1;
      if (v >= (1 << (ADC_BITS-1))) v -= (1 << ADC_BITS);
      p[k*16 +: 16] = 16'(v);
    end
    return p;
  endfunction

  function automatic bit ovr_of(input logic [NSAMP*SW-1:0] b);
    bit o = 0;
    for (int k = 0; k < NSAMP; k++) o |= b[k*SW];
    return o;
  endfunction

  function automatic pay_t fill_hdr_m();
    pay_t p = '0;
    p[23:0] = m_fn; p[25:24] = m_ft; p[40:27] = m_nb; p[52:41] = m_pt[11:0];
    p[75:53] = m_adr; p[98:76] = m_nwf; p[102:99] = m_pt[15:12]; p[103] = m_cb;
    p[121:110] = m_tag; p[127:126] = 2'b01;
    return p;
  endfunction

  function automatic pay_t wf_hdr_m(input int w);
    pay_t p = '0;
    longint a = (longint'(m_adr) + longint'(w) * longint'(m_nb) * (NSAMP/8)) % (64'd1 << 23);
    logic [22:0] a23 = a[22:0];
    logic [22:0] w23 = w[22:0];
    p[13:0] = m_nb; p[25:14] = m_pt[11:0]; p[51:26] = {a23, 3'b000}; p[74:52] = w23;
    p[109:98] = m_tag; p[113:110] = m_xa; p[114] = m_cb; p[127:126] = 2'b01;
    return p;
  endfunction

  // Input stimulus and output backpressure.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 9) < 7);
      default: begin bus.out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3); rcnt++; end
    endcase
    bus.in_valid = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < NSAMP; k++) bus.in_dat[k*SW +: SW] = SW'($urandom);
    if (force_lane0) bus.in_dat[SW-1:0] = {SW{1'b1}};
  end

  // Scoreboard: every accepted output word against the model stream.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) chk("stall_hold", {bus.out_valid, bus.out_dat}, {1'b1, stall_word});
      stalled = bus.out_valid && !bus.out_ready;
      if (stalled) begin
        stall_word = bus.out_dat;
        chk("in_ready_stall", bus.in_ready, 1'b0);
      end
      if (bus.in_valid && bus.in_ready) beat_q.push_back(bus.in_dat);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_tag.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_word: got %h expected none", bus.out_dat);
        end else begin
          ct = exp_tag.pop_front();
          cp = exp_pay.pop_front();
          case (ct)
            4'd1: begin m_csum = cp; m_wf_ovr = 0; m_fill_ovr = 0; end
            4'd2: begin
`ifdef OVR_FLAG_EN
              cp[115] = m_wf_ovr;
`endif
              m_wf_ovr = 0;
              m_csum ^= cp;
            end
            4'd3: begin
              if (beat_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL data_no_beat: got %h expected an accepted beat", bus.out_dat);
              end else begin
                cb = beat_q.pop_front();
                cp = data_of(cb);
                if (ovr_of(cb)) begin m_wf_ovr = 1; m_fill_ovr = 1; end
              end
              m_csum ^= cp;
            end
            default: begin cp = m_csum; csum_seen = 1; end
          endcase
          chk("word", bus.out_dat, {ct, cp});
        end
        got_tag.push_back(bus.out_dat[DW+3:DW]);
        got_pay.push_back(bus.out_dat[DW-1:0]);
      end
    end
  end

  task automatic scramble_cfg();
    fill_num = $urandom; fill_type = 2'($urandom); cbuf_mode = 1'($urandom);
    channel_tag = 12'($urandom); burst_start_adr = 23'($urandom); num_bursts = 14'($urandom);
    pre_trig = 16'($urandom); num_waveforms = 23'($urandom);
  endtask

  task automatic begin_fill(input logic [23:0] fn, input logic [22:0] nwf, input logic [13:0] nb,
                            input logic [22:0] adr);
    @(posedge clk); #1;
    m_fn = fn; m_ft = 2'($urandom); m_cb = 1'($urandom); m_tag = 12'($urandom);
    m_adr = adr; m_nb = nb; m_pt = 16'($urandom); m_nwf = nwf; m_xa = 4'($urandom);
    fill_num = m_fn; fill_type = m_ft; cbuf_mode = m_cb; channel_tag = m_tag;
    burst_start_adr = m_adr; num_bursts = m_nb; pre_trig = m_pt; num_waveforms = m_nwf;
    xadc_alarms = m_xa;
    exp_tag.delete(); exp_pay.delete(); got_tag.delete(); got_pay.delete(); beat_q.delete();
    csum_seen = 0;
    exp_tag.push_back(4'd1); exp_pay.push_back(fill_hdr_m());
    for (int w = 0; w < int'(nwf); w++) begin
      exp_tag.push_back(4'd2); exp_pay.push_back(wf_hdr_m(w));
      for (int b = 0; b < int'(nb); b++) begin exp_tag.push_back(4'd3); exp_pay.push_back('0); end
    end
    exp_tag.push_back(4'd4); exp_pay.push_back('0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_cfg();
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic end_fill();
    bit done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (csum_seen) begin done = 1; break; end
      #1;
      start = ($urandom_range(0, 7) == 0);
      scramble_cfg();
    end
    #1 start = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL fill_timeout: got no checksum expected one within budget"); end
    @(negedge clk);
    chk("busy_after_csum", busy, 1'b0);
    chk("exp_drained", exp_tag.size(), 0);
`ifdef OVR_FLAG_EN
    chk("ovr_seen", ovr_seen, m_fill_ovr);
`else
    chk("ovr_seen", ovr_seen, 1'b0);
`endif
  endtask

  task automatic run_fill(input logic [23:0] fn, input logic [22:0] nwf, input logic [13:0] nb,
                          input logic [22:0] adr);
    begin_fill(fn, nwf, nb, adr);
    end_fill();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_dat = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_dat", bus.out_dat, '0);
    chk("rst_ovr_seen", ovr_seen, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    rdy_mode = 0;
    run_fill(24'd5, 23'd2, 14'd3, 23'h100);
    chk("t1_count", got_tag.size(), 10);
    if (got_tag.size() == 10) begin
      accx = '0;
      for (int i = 0; i < 10; i++) chk("t1_tag", got_tag[i], t1_tags[i]);
      for (int i = 0; i < 9; i++) accx ^= got_pay[i];
      chk("t1_wf1_adr", got_pay[5][51:26], 26'h818);
      chk("t1_wf1_idx", got_pay[5][74:52], 23'd1);
      chk("t1_csum", got_pay[9], accx);
    end

    run_fill(24'd7, 23'd0, 14'd5, 23'h1234);
    chk("t2_count", got_tag.size(), 2);
    if (got_tag.size() == 2) chk("t2_csum_eq_hdr", got_pay[1], got_pay[0]);

    rdy_mode = 2; rcnt = 0;
    run_fill(24'($urandom), 23'd2, 14'd4, 23'($urandom));
    chk("t3_count", got_tag.size(), 12);

    rdy_mode = 0; force_lane0 = 1;
    run_fill(24'd11, 23'd2, 14'd2, 23'h40);
    force_lane0 = 0;
    if (got_tag.size() == 8) begin
      chk("t4_lane0", got_pay[2][15:0], 16'hFFFF);
`ifdef OVR_FLAG_EN
      chk("t4_wf1_ovr", got_pay[4][115], 1'b1);
      chk("t4_ovr_seen", ovr_seen, 1'b1);
`else
      chk("t4_wf1_ovr", got_pay[4][115], 1'b0);
`endif
    end else chk("t4_count", got_tag.size(), 8);

    run_fill(24'd12, 23'd2, 14'd2, 23'h7FFFFF);
    if (got_tag.size() == 8) chk("t5_wrap_adr", got_pay[4][51:26], 26'h8);
    else chk("t5_count", got_tag.size(), 8);

    rdy_mode = 1;
    for (int f = 0; f < 12; f++)
      run_fill(24'($urandom), 23'($urandom_range(0, 3)), 14'($urandom_range(0, 4)), 23'($urandom));

    begin_fill(24'd9, 23'd2, 14'd4, 23'h55);
    for (int i = 0; i < 300 && got_tag.size() < 3; i++) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    exp_tag.delete(); exp_pay.delete(); beat_q.delete(); got_tag.delete(); got_pay.delete();
    csum_seen = 0;
    @(posedge clk); #1 rst = 1'b0;
    run_fill(24'd10, 23'd1, 14'd2, 23'h77);
    chk("t6_count", got_tag.size(), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
